cache_2way_wt: RTL

- Parametrised successor to the direct-mapped CACHE block: a 2-way set-associative, write-through, no-write-allocate cache with per-set LRU replacement.
- Block size, set count and data/address widths are parameters.
- Sits between a pipeline stage and the multi-cycle memory: used as the I-cache (pipe_MemWrite tied 0) and as the D-cache.
- Fills a whole block on a read miss with pipelined word requests.

---
 rtl/cache_pkg.sv | 41 ++++
 rtl/cache_way_array.sv | 68 ++++++
 rtl/cache_2way_wt.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types and address-split helpers for the 2-way write-through cache.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
//
// Holds the controller state encoding, constant functions that derive the
// byte/offset/index/tag field widths from the cache parameters, and tag/line
// types for the default configuration.
package cache_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WRITE = 2'd2
   } state_t;

   // Byte-select bits below the word offset.
   function automatic int byte_w_f(input int data_w);
      return $clog2(data_w / 8);
   endfunction

   function automatic int off_w_f(input int wpb);
      return $clog2(wpb);
   endfunction

   function automatic int idx_w_f(input int num_sets);
      return $clog2(num_sets);
   endfunction

   function automatic int tag_w_f(input int addr_w, input int data_w,
                                  input int wpb, input int num_sets);
      return addr_w - byte_w_f(data_w) - off_w_f(wpb) - idx_w_f(num_sets);
   endfunction

   // Default configuration: 16-bit words, 16-bit addresses, 8 words/line, 64 sets.
   localparam int DEF_TAG_W  = tag_w_f(16, 16, 8, 64);
   localparam int DEF_LINE_W = 16 * 8;

   typedef logic [DEF_TAG_W-1:0]  tag_t;
   typedef logic [DEF_LINE_W-1:0] line_t;

endpackage

// File: rtl/cache_way_array.sv
// One cache way: per-set valid bit, tag and word-addressed data storage.
// Latency: combinational read; writes and valid updates take effect at the clock edge.
// Backpressure: none; the controller sequences all accesses.
//
// Ports:
//   clk_i, rst_ni        clock / async active-low reset (clears valid bits only)
//   rd_idx_i, rd_off_i   lookup set and word; rd_vld_o/rd_tag_o/rd_dat_o return it
//   wr_en_i ...          word write (fill or write-hit)
//   vld_set_i/vld_clr_i  mark set vld_idx_i valid (with tag_i) or invalid
module cache_way_array
   import cache_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int NUM_SETS = 64,
   parameter int WPB      = 8,
   parameter int OFF_W    = 3,
   parameter int IDX_W    = 6,
   parameter int TAG_W    = 6
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [IDX_W-1:0]  rd_idx_i,
   input  logic [OFF_W-1:0]  rd_off_i,
   output logic              rd_vld_o,
   output logic [TAG_W-1:0]  rd_tag_o,
   output logic [DATA_W-1:0] rd_dat_o,
   input  logic              wr_en_i,
   input  logic [IDX_W-1:0]  wr_idx_i,
   input  logic [OFF_W-1:0]  wr_off_i,
   input  logic [DATA_W-1:0] wr_dat_i,
   input  logic              vld_set_i,
   input  logic              vld_clr_i,
   input  logic [IDX_W-1:0]  vld_idx_i,
   input  logic [TAG_W-1:0]  tag_i
);

   logic [NUM_SETS-1:0] vld_q;
   logic [TAG_W-1:0]    tag_q  [NUM_SETS];
   logic [DATA_W-1:0]   data_q [NUM_SETS*WPB];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_q <= '0;
      end else if (vld_set_i) begin
         vld_q[vld_idx_i] <= 1'b1;
      end else if (vld_clr_i) begin
         vld_q[vld_idx_i] <= 1'b0;
      end
   end

   // Tag and data storage carry no reset; the valid bit guards them.
   always_ff @(posedge clk_i) begin
      if (vld_set_i) begin
         tag_q[vld_idx_i] <= tag_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         data_q[{wr_idx_i, wr_off_i}] <= wr_dat_i;
      end
   end

   assign rd_vld_o = vld_q[rd_idx_i];
   assign rd_tag_o = tag_q[rd_idx_i];
   assign rd_dat_o = data_q[{rd_idx_i, rd_off_i}];

endmodule

// File: rtl/cache_2way_wt.sv
// 2-way set-associative write-through, no-write-allocate cache with per-set LRU.
// Latency: read hit same cycle; read miss = memory latency + WORDS_PER_BLOCK + 1; write 2 cycles.
// Backpressure: CacheBusy holds the pipeline during FILL and WRITE; pipe inputs ignored then.
//
// Ports:
//   pipe_*        pipeline read/write requests (write wins when both are set)
//   cache_Mem*    word requests / write-through traffic to memory
//   MemDataValid, mem_read_data   in-order fill returns
//   cache_data_out, CacheHit, CacheDone, CacheBusy   status back to the pipeline
module cache_2way_wt
   import cache_pkg::*;
#(
   parameter int DATA_W          = 16,
   parameter int ADDR_W          = 16,
   parameter int WORDS_PER_BLOCK = 8,
   parameter int NUM_SETS        = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pipe_MemRead,
   input  logic [ADDR_W-1:0] pipe_read_addr,
   input  logic              pipe_MemWrite,
   input  logic [ADDR_W-1:0] pipe_mem_write_addr,
   input  logic [DATA_W-1:0] pipe_mem_write_data,
   input  logic              MemDataValid,
   input  logic [DATA_W-1:0] mem_read_data,
   output logic              cache_MemRead,
   output logic              cache_MemWrite,
   output logic [ADDR_W-1:0] cache_mem_addr,
   output logic [DATA_W-1:0] cache_mem_write_data,
   output logic [DATA_W-1:0] cache_data_out,
   output logic              CacheHit,
   output logic              CacheDone,
   output logic              CacheBusy
);

   localparam int BYTE_W = byte_w_f(DATA_W);
   localparam int OFF_W  = off_w_f(WORDS_PER_BLOCK);
   localparam int IDX_W  = idx_w_f(NUM_SETS);
   localparam int TAG_W  = tag_w_f(ADDR_W, DATA_W, WORDS_PER_BLOCK, NUM_SETS);
   localparam int CNT_W  = OFF_W + 1;
   localparam int BLK_W  = ADDR_W - BYTE_W;

   localparam logic [CNT_W-1:0] CNT_WPB  = CNT_W'(WORDS_PER_BLOCK);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS_PER_BLOCK - 1);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t              state_q, state_d;
   logic [TAG_W-1:0]    tag_q, tag_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                victim_q, victim_d;
   logic [CNT_W-1:0]    req_cnt_q, req_cnt_d;
   logic [CNT_W-1:0]    rcv_cnt_q, rcv_cnt_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic [NUM_SETS-1:0] lru_q, lru_d;   // per set: the way to evict next

   // ------------------------------------------------------------------
   // Lookup: a write request borrows the single lookup port ahead of a read
   // ------------------------------------------------------------------
   logic [OFF_W-1:0]  lk_off;
   logic [IDX_W-1:0]  lk_idx;
   logic [TAG_W-1:0]  lk_tag;
   logic [ADDR_W-1:0] lk_addr;

   assign lk_addr = pipe_MemWrite ? pipe_mem_write_addr : pipe_read_addr;
   assign lk_off  = lk_addr[BYTE_W +: OFF_W];
   assign lk_idx  = lk_addr[BYTE_W + OFF_W +: IDX_W];
   assign lk_tag  = lk_addr[BYTE_W + OFF_W + IDX_W +: TAG_W];

   logic [1:0]        way_vld;
   logic [TAG_W-1:0]  way_tag [2];
   logic [DATA_W-1:0] way_dat [2];
   logic [1:0]        way_hit;
   logic [1:0]        way_wr_en, way_vld_set, way_vld_clr;

   logic              lk_hit, hit_way, victim_sel;
   logic [DATA_W-1:0] lk_data;

   assign way_hit[0] = way_vld[0] && (way_tag[0] == lk_tag);
   assign way_hit[1] = way_vld[1] && (way_tag[1] == lk_tag);
   assign lk_hit     = |way_hit;
   assign hit_way    = way_hit[1];
   assign lk_data    = hit_way ? way_dat[1] : way_dat[0];

   // Prefer an empty way; otherwise evict the LRU way of the set.
   assign victim_sel = !way_vld[0] ? 1'b0 :
                       !way_vld[1] ? 1'b1 : lru_q[lk_idx];

   // ------------------------------------------------------------------
   // Request / fill events
   // ------------------------------------------------------------------
   logic in_idle, in_fill, rd_req, rd_hit, rd_miss, wr_req, wr_hit;
   logic fill_rx, fill_last, req_pending;

   assign in_idle     = (state_q == IDLE);
   assign in_fill     = (state_q == FILL);
   assign wr_req      = in_idle && pipe_MemWrite;
   assign rd_req      = in_idle && pipe_MemRead && !pipe_MemWrite;
   assign rd_hit      = rd_req && lk_hit;
   assign rd_miss     = rd_req && !lk_hit;
   assign wr_hit      = wr_req && lk_hit;
   assign req_pending = in_fill && (req_cnt_q < CNT_WPB);
   // Returns beyond the block size are dropped so a stray pulse cannot overrun.
   assign fill_rx     = in_fill && MemDataValid && (rcv_cnt_q < CNT_WPB);
   assign fill_last   = fill_rx && (rcv_cnt_q == CNT_LAST);

   // ------------------------------------------------------------------
   // Way storage
   // ------------------------------------------------------------------
   logic [IDX_W-1:0]  arr_wr_idx;
   logic [OFF_W-1:0]  arr_wr_off;
   logic [DATA_W-1:0] arr_wr_dat;
   logic [IDX_W-1:0]  arr_vld_idx;

   assign arr_wr_idx  = in_fill ? idx_q : lk_idx;
   assign arr_wr_off  = in_fill ? rcv_cnt_q[OFF_W-1:0] : lk_off;
   assign arr_wr_dat  = in_fill ? mem_read_data : pipe_mem_write_data;
   assign arr_vld_idx = in_fill ? idx_q : lk_idx;

   for (genvar w = 0; w < 2; w++) begin : g_way
      assign way_wr_en[w]   = (wr_hit && (hit_way == 1'(w))) ||
                              (fill_rx && (victim_q == 1'(w)));
      assign way_vld_set[w] = fill_last && (victim_q == 1'(w));
      // The victim is invalidated up front so a partial fill never hits.
      assign way_vld_clr[w] = rd_miss && (victim_sel == 1'(w));

      cache_way_array #(
         .DATA_W   (DATA_W),
         .NUM_SETS (NUM_SETS),
         .WPB      (WORDS_PER_BLOCK),
         .OFF_W    (OFF_W),
         .IDX_W    (IDX_W),
         .TAG_W    (TAG_W)
      ) u_way (
         .clk_i     (clk),
         .rst_ni    (rst_n),
         .rd_idx_i  (lk_idx),
         .rd_off_i  (lk_off),
         .rd_vld_o  (way_vld[w]),
         .rd_tag_o  (way_tag[w]),
         .rd_dat_o  (way_dat[w]),
         .wr_en_i   (way_wr_en[w]),
         .wr_idx_i  (arr_wr_idx),
         .wr_off_i  (arr_wr_off),
         .wr_dat_i  (arr_wr_dat),
         .vld_set_i (way_vld_set[w]),
         .vld_clr_i (way_vld_clr[w]),
         .vld_idx_i (arr_vld_idx),
         .tag_i     (tag_q)
      );
   end

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (pipe_MemWrite) begin
               state_d = WRITE;
            end else if (pipe_MemRead && !lk_hit) begin
               state_d = FILL;
            end
         end
         FILL: begin
            if (fill_last) begin
               state_d = IDLE;
            end
         end
         WRITE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM: outputs
   logic [BLK_W-1:0]  fill_word;
   logic [ADDR_W-1:0] fill_addr;

   assign fill_word = {tag_q, idx_q, req_cnt_q[OFF_W-1:0]};
   assign fill_addr = ADDR_W'(fill_word) << BYTE_W;

   always_comb begin
      cache_MemRead        = 1'b0;
      cache_MemWrite       = 1'b0;
      cache_mem_addr       = '0;
      cache_mem_write_data = '0;
      cache_data_out       = '0;
      CacheHit             = 1'b0;
      CacheDone            = 1'b0;
      CacheBusy            = 1'b0;
      case (state_q)
         IDLE: begin
            CacheHit  = rd_hit;
            CacheDone = rd_hit;
            if (rd_hit) begin
               cache_data_out = lk_data;
            end
         end
         FILL: begin
            CacheBusy = 1'b1;
            if (req_pending) begin
               cache_MemRead  = 1'b1;
               cache_mem_addr = fill_addr;
            end
         end
         WRITE: begin
            CacheBusy            = 1'b1;
            CacheDone            = 1'b1;
            cache_MemWrite       = 1'b1;
            cache_mem_addr       = wr_addr_q;
            cache_mem_write_data = wr_data_q;
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   always_comb begin
      tag_d     = tag_q;
      idx_d     = idx_q;
      victim_d  = victim_q;
      req_cnt_d = req_cnt_q;
      rcv_cnt_d = rcv_cnt_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      lru_d     = lru_q;

      if (wr_req) begin
         wr_addr_d = pipe_mem_write_addr;
         wr_data_d = pipe_mem_write_data;
      end
      if (rd_miss) begin
         tag_d     = lk_tag;
         idx_d     = lk_idx;
         victim_d  = victim_sel;
         req_cnt_d = '0;
         rcv_cnt_d = '0;
      end
      if (req_pending) begin
         req_cnt_d = req_cnt_q + CNT_W'(1);
      end
      if (fill_rx) begin
         rcv_cnt_d = rcv_cnt_q + CNT_W'(1);
      end

      if (rd_hit || wr_hit) begin
         lru_d[lk_idx] = ~hit_way;
      end
      if (fill_last) begin
         lru_d[idx_q] = ~victim_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_q     <= '0;
         idx_q     <= '0;
         victim_q  <= 1'b0;
         req_cnt_q <= '0;
         rcv_cnt_q <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         lru_q     <= '0;
      end else begin
         tag_q     <= tag_d;
         idx_q     <= idx_d;
         victim_q  <= victim_d;
         req_cnt_q <= req_cnt_d;
         rcv_cnt_q <= rcv_cnt_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         lru_q     <= lru_d;
      end
   end

   // Byte-select bits of the read address never influence a word lookup.
   if (BYTE_W > 0) begin : g_byte
      logic unused_byte_bits;
      assign unused_byte_bits = ^pipe_read_addr[BYTE_W-1:0];
   end

endmodule
